// File: rtl/rtc_bus_interface.sv
// Bus stage between the RTC control FSM and the multiplexed A/D pad: sequences one
// address strobe and one data strobe per request and reports completion with a pulse.
module rtc_bus_interface #(
    parameter int T_STB = 8,
    parameter int T_REC = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       win,
    input  logic       rin,
    input  logic [7:0] address,
    input  logic [7:0] data_wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       donew,
    output logic       doner,
    output logic [7:0] data_rd
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_STB,
        ADDR_REC,
        DATA_STB,
        DATA_REC,
        DONE
    } state_t;

    localparam logic [7:0] STB_LOAD = 8'(T_STB - 1);
    localparam logic [7:0] REC_LOAD = 8'(T_REC - 1);

    state_t     state;
    logic [7:0] count;
    logic       op_write;
    logic [7:0] data_q;

    // Every output is registered and set on the edge that enters the phase it belongs to,
    // so each phase lasts exactly count+1 cycles and reset clears the pins immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 8'd0;
            op_write <= 1'b0;
            data_q   <= 8'd0;
            ad_out   <= 8'd0;
            ad_oe    <= 1'b0;
            cs_n     <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            a_d      <= 1'b1;
            donew    <= 1'b0;
            doner    <= 1'b0;
            data_rd  <= 8'd0;
        end else begin
            donew <= 1'b0;
            doner <= 1'b0;
            case (state)
                IDLE: begin
                    cs_n  <= 1'b1;
                    rd_n  <= 1'b1;
                    wr_n  <= 1'b1;
                    ad_oe <= 1'b0;
                    // win wins when both enables are up; the address goes out with wr_n
                    // for reads as well.
                    if (win || rin) begin
                        op_write <= win;
                        data_q   <= data_wr;
                        ad_out   <= address;
                        ad_oe    <= 1'b1;
                        a_d      <= 1'b0;
                        cs_n     <= 1'b0;
                        wr_n     <= 1'b0;
                        count    <= STB_LOAD;
                        state    <= ADDR_STB;
                    end
                end
                ADDR_STB: begin
                    if (count == 8'd0) begin
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        count <= REC_LOAD;
                        state <= ADDR_REC;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                ADDR_REC: begin
                    if (count == 8'd0) begin
                        a_d   <= 1'b1;
                        cs_n  <= 1'b0;
                        count <= STB_LOAD;
                        state <= DATA_STB;
                        if (op_write) begin
                            ad_oe  <= 1'b1;
                            ad_out <= data_q;
                            wr_n   <= 1'b0;
                        end else begin
                            ad_oe <= 1'b0;
                            rd_n  <= 1'b0;
                        end
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                DATA_STB: begin
                    if (count == 8'd0) begin
                        if (!op_write) begin
                            data_rd <= ad_in;
                        end
                        cs_n  <= 1'b1;
                        rd_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        count <= REC_LOAD;
                        state <= DATA_REC;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                DATA_REC: begin
                    if (count == 8'd0) begin
                        ad_oe <= 1'b0;
                        donew <= op_write;
                        doner <= ~op_write;
                        state <= DONE;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_interface.sv
// Directed bench for rtc_bus_interface: table of transactions checked cycle by cycle
// against a phase model, plus a hand-written asynchronous-reset sequence.
module tb_rtc_bus_interface;

    localparam int T_STB = 8;
    localparam int T_REC = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       win;
    logic       rin;
    logic [7:0] address;
    logic [7:0] data_wr;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       donew;
    logic       doner;
    logic [7:0] data_rd;

    logic [7:0] bus_rd_value;
    logic [7:0] exp_data_rd;
    int         vectors_applied = 0;
    int         miscompares = 0;

    typedef struct {
        logic       win;
        logic       rin;
        logic [7:0] address;
        logic [7:0] data_wr;
        logic [7:0] rd_value;
        logic       hold;
        int         drop_at;
        logic       scramble;
    } vec_t;

    vec_t vecs[9];

    rtc_bus_interface #(.T_STB(T_STB), .T_REC(T_REC)) dut (
        .clock   (clock),
        .reset   (reset),
        .win     (win),
        .rin     (rin),
        .address (address),
        .data_wr (data_wr),
        .ad_in   (ad_in),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .cs_n    (cs_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .a_d     (a_d),
        .donew   (donew),
        .doner   (doner),
        .data_rd (data_rd)
    );

    always #5 clock = ~clock;

    // RTC model: drives the read value only while rd_n is low, junk otherwise.
    assign ad_in = rd_n ? 8'hEE : bus_rd_value;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bit order: cs_n rd_n wr_n a_d ad_oe donew doner ad_out[7:0] data_rd[7:0]
    function automatic logic [22:0] pack(logic c, logic r, logic w, logic ad, logic oe,
                                         logic dw, logic dr, logic [7:0] o, logic [7:0] d);
        return {c, r, w, ad, oe, dw, dr, o, d};
    endfunction

    // Expected pins in cycle j (1 = first ADDR_STB cycle) of a transaction.
    function automatic logic [22:0] expect_at(int j, logic is_wr, logic [7:0] a,
                                              logic [7:0] d, logic [7:0] rd_old,
                                              logic [7:0] rd_new);
        logic [7:0] rdv;
        rdv = (j > 2 * T_STB + T_REC) ? rd_new : rd_old;
        if (j <= T_STB)
            return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, rdv);
        else if (j <= T_STB + T_REC)
            return pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a, rdv);
        else if (j <= 2 * T_STB + T_REC)
            return is_wr ? pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, d, rdv)
                         : pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, rdv);
        else if (j <= 2 * (T_STB + T_REC))
            return pack(1'b1, 1'b1, 1'b1, 1'b1, is_wr, 1'b0, 1'b0, d, rdv);
        else if (j == 2 * (T_STB + T_REC) + 1)
            return pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, is_wr, ~is_wr, 8'h00, rdv);
        else
            return pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, rdv);
    endfunction

    task automatic checkOutput(input string name, input logic [22:0] expected,
                               input logic check_ad_out);
        logic [22:0] actual;
        logic [22:0] care;
        actual = pack(cs_n, rd_n, wr_n, a_d, ad_oe, donew, doner, ad_out, data_rd);
        care = '1;
        if (!check_ad_out && !expected[18])
            care[15:8] = 8'h00;
        vectors_applied++;
        if (((actual ^ expected) & care) != 23'd0) begin
            miscompares++;
            $display("[TB] FAIL %s: got strobes cs/rd/wr/a_d/oe/dw/dr=%b ad_out=%h data_rd=%h, expected %b ad_out=%h data_rd=%h",
                     name, actual[22:16], actual[15:8], actual[7:0],
                     expected[22:16], expected[15:8], expected[7:0]);
        end
    endtask

    // Called in an idle cycle at the falling edge; ends in the idle cycle after DONE.
    task automatic applyStimulus(input int idx, input vec_t v);
        logic [7:0] rd_old;
        logic [7:0] rd_new;
        win          = v.win;
        rin          = v.rin;
        address      = v.address;
        data_wr      = v.data_wr;
        bus_rd_value = v.rd_value;
        rd_old       = exp_data_rd;
        rd_new       = v.win ? rd_old : v.rd_value;
        for (int j = 1; j <= 2 * (T_STB + T_REC) + 2; j++) begin
            @(negedge clock);
            checkOutput($sformatf("vec%0d cyc%0d", idx, j),
                        expect_at(j, v.win, v.address, v.data_wr, rd_old, rd_new), 1'b0);
            if (j == v.drop_at) begin
                win = 1'b0;
                rin = 1'b0;
            end
            if (v.scramble && j == 5) begin
                address = ~v.address;
                data_wr = ~v.data_wr;
            end
            if (j == 2 * (T_STB + T_REC) + 1 && !v.hold) begin
                @(posedge clock);
                #1;
                win = 1'b0;
                rin = 1'b0;
            end
        end
        exp_data_rd = rd_new;
    endtask

    initial begin
        //           win   rin   addr   data   rdval  hold  drop scramble
        vecs[0] = '{1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 1'b0, 0,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h26, 8'h00, 8'h16, 1'b0, 0,  1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h02, 8'h10, 8'h00, 1'b1, 0,  1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h11, 8'h00, 1'b1, 0,  1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h21, 8'h12, 8'h00, 1'b0, 0,  1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'hF1, 8'h33, 8'h77, 1'b0, 0,  1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'hF2, 8'h5A, 8'h00, 1'b0, 10, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'h80, 8'h00, 8'hA5, 1'b0, 0,  1'b1};
        vecs[8] = '{1'b1, 1'b0, 8'h7E, 8'h81, 8'h00, 1'b0, 0,  1'b1};

        reset        = 1'b1;
        win          = 1'b0;
        rin          = 1'b0;
        address      = 8'h00;
        data_wr      = 8'h00;
        bus_rd_value = 8'h00;
        exp_data_rd  = 8'h00;

        @(negedge clock);
        @(negedge clock);
        checkOutput("reset values",
                    pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("idle after reset",
                    pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1);

        for (int i = 0; i < 9; i++)
            applyStimulus(i, vecs[i]);

        // Reset asserted inside DATA_STB of a write must clear the pins before any edge.
        win     = 1'b1;
        address = 8'h33;
        data_wr = 8'h44;
        for (int j = 1; j <= T_STB + T_REC + 3; j++)
            @(negedge clock);
        checkOutput("in data strobe before reset",
                    pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, exp_data_rd), 1'b1);
        #2;
        reset = 1'b1;
        win   = 1'b0;
        #1;
        checkOutput("async reset mid write",
                    pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1);
        exp_data_rd = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clock);
            checkOutput($sformatf("quiet after reset cyc%0d", j),
                        pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00), 1'b1);
        end

        applyStimulus(9, '{1'b1, 1'b0, 8'h55, 8'hC3, 8'h00, 1'b0, 0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
